// File: rtl/lcd_1602a_responder.sv
// lcd_1602a_responder
//   Behavioural responder for an HD44780-style 1602A character LCD, seen from
//   the host controller's side of the bus. Decodes instructions and data
//   writes, keeps an 80-byte DDRAM, models the busy flag with a cycle counter,
//   and answers busy-flag/address and data reads.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   lcd_ctrl          : {RS, RW, E} from the host
//   lcd_data_in       : host data bus (DB7..DB4 only when MODE=1)
//   lcd_data_out/_oe  : read data and bus-drive enable from the responder
//   busy              : busy flag (BF)
//   ddram_addr        : address counter (AC)
//   four_bit, two_line, disp_on, cursor_on, blink_on : configuration bits
//   proto_err         : sticky protocol error
//   rd_addr / rd_char : debug DDRAM read port, one cycle latency
module lcd_1602a_responder #(
    parameter int MODE         = 1,
    parameter int CMD_CYCLES   = 1008,
    parameter int CLEAR_CYCLES = 39360,
    parameter int COUNT_SIZE   = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              lcd_ctrl,
    input  logic [8-(MODE*4)-1:0]   lcd_data_in,
    output logic [8-(MODE*4)-1:0]   lcd_data_out,
    output logic                    lcd_data_oe,
    output logic                    busy,
    output logic [6:0]              ddram_addr,
    output logic                    four_bit,
    output logic                    two_line,
    output logic                    disp_on,
    output logic                    cursor_on,
    output logic                    blink_on,
    output logic                    proto_err,
    input  logic [6:0]              rd_addr,
    output logic [7:0]              rd_char
);

    localparam int DW = 8 - MODE * 4;

    typedef enum logic [1:0] {S_FILL, S_IDLE, S_BUSY} state_t;
    state_t state, state_next;

    logic rs, rw, e;
    assign rs = lcd_ctrl[2];
    assign rw = lcd_ctrl[1];
    assign e  = lcd_ctrl[0];

    logic                  e_q, strobe, e_rise;
    logic                  four_state, byte_done, busy_w, exec_wr, fill_done;
    logic [7:0]            wr_byte, rd_byte;
    logic [DW-1:0]         rd_bus, data_out_q;
    logic                  oe_q;
    logic [6:0]            ac, fill_cnt, rd_idx;
    logic                  id, dl, n_lines, d_on, c_on, b_on, phase_lo, perr;
    logic [COUNT_SIZE-1:0] cnt;
    logic [7:0]            rd_char_q;
    logic [7:0]            ddram [0:79];
    logic                  do_clear, do_home, do_setac, do_func, do_disp, do_entry, do_data;

    // Line 1 (0x00-0x27) maps to storage 0-39, line 2 (0x40-0x67) to 40-79.
    function automatic logic [6:0] ac_index(input logic [6:0] a);
        return a[6] ? 7'(a[5:0]) + 7'd40 : 7'(a[5:0]);
    endfunction

    function automatic logic ac_valid(input logic [6:0] a);
        return a[5:0] < 6'h28;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == 7'h27)      return 7'h40;
            else if (a == 7'h67) return 7'h00;
            else                 return a + 7'd1;
        end else begin
            if (a == 7'h00)      return 7'h67;
            else if (a == 7'h40) return 7'h27;
            else                 return a - 7'd1;
        end
    endfunction

    assign strobe     = e_q && !e;
    assign e_rise     = e && !e_q;
    assign busy_w     = (state != S_IDLE);
    assign fill_done  = (state == S_FILL) && (fill_cnt == 7'd79);
    assign four_state = (MODE == 1) && !dl;
    assign byte_done  = !four_state || phase_lo;
    assign exec_wr    = strobe && !rw && byte_done && !busy_w;
    assign rd_byte    = rs ? ddram[ac_index(ac)] : {busy_w, ac};
    assign rd_idx     = ac_index(rd_addr);

    if (MODE == 0) begin : g_bus8
        assign wr_byte = lcd_data_in;
        assign rd_bus  = rd_byte;
    end else begin : g_bus4
        logic [3:0] hi_nib;
        // High nibble is only latched by an accepted first-half write.
        always_ff @(posedge clk) begin
            if (rst)
                hi_nib <= '0;
            else if (strobe && !rw && four_state && !phase_lo && !busy_w)
                hi_nib <= lcd_data_in;
        end
        assign wr_byte = four_state ? {hi_nib, lcd_data_in} : {lcd_data_in, 4'h0};
        assign rd_bus  = (four_state && phase_lo) ? rd_byte[3:0] : rd_byte[7:4];
    end

    // Instruction decode by highest set bit.
    always_comb begin
        do_clear = 1'b0; do_home = 1'b0; do_setac = 1'b0; do_func = 1'b0;
        do_disp  = 1'b0; do_entry = 1'b0; do_data = 1'b0;
        if (rs) begin
            do_data = 1'b1;
        end else begin
            casez (wr_byte)
                8'b1???????: do_setac = 1'b1;
                8'b001?????: do_func  = 1'b1;
                8'b00001???: do_disp  = 1'b1;
                8'b000001??: do_entry = 1'b1;
                8'b0000001?: do_home  = 1'b1;
                8'b00000001: do_clear = 1'b1;
                default:     ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FILL:  if (fill_done) state_next = S_BUSY;
            S_IDLE:  if (exec_wr) state_next = do_clear ? S_FILL : S_BUSY;
            S_BUSY:  if (cnt == '0) state_next = S_IDLE;
            default: state_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_FILL;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (fill_done || (exec_wr && do_home))
            cnt <= COUNT_SIZE'(CLEAR_CYCLES);
        else if (exec_wr && !do_clear)
            cnt <= COUNT_SIZE'(CMD_CYCLES);
        else if (state == S_BUSY && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || state != S_FILL) fill_cnt <= '0;
        else                        fill_cnt <= fill_cnt + 7'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_FILL)
                ddram[fill_cnt] <= 8'h20;
            else if (exec_wr && do_data)
                ddram[ac_index(ac)] <= wr_byte;
        end
    end

    always_ff @(posedge clk) begin
        rd_char_q <= (rd_idx < 7'd80) ? ddram[rd_idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= 1'b0; oe_q <= 1'b0; data_out_q <= '0;
            ac <= '0; id <= 1'b1; dl <= 1'b1; n_lines <= 1'b0;
            d_on <= 1'b0; c_on <= 1'b0; b_on <= 1'b0;
            phase_lo <= 1'b0; perr <= 1'b0;
        end else begin
            e_q  <= e;
            oe_q <= e && rw;
            if (e_rise && rw) data_out_q <= rd_bus;
            if (strobe && four_state) phase_lo <= !phase_lo;
            if (strobe && !rw && busy_w) perr <= 1'b1;
            if (strobe && rw && rs) begin
                if (busy_w)         perr <= 1'b1;
                else if (byte_done) ac <= ac_step(ac, id);
            end
            if (fill_done) ac <= '0;
            if (exec_wr) begin
                if (do_data) ac <= ac_step(ac, id);
                if (do_home) ac <= '0;
                if (do_clear) id <= 1'b1;
                if (do_entry) id <= wr_byte[1];
                if (do_disp) begin
                    d_on <= wr_byte[2]; c_on <= wr_byte[1]; b_on <= wr_byte[0];
                end
                if (do_func) begin
                    dl <= wr_byte[4]; n_lines <= wr_byte[3];
                    // Entering 4-bit mode re-aligns the pairing; overrides the toggle above.
                    if (!wr_byte[4]) phase_lo <= 1'b0;
                end
                if (do_setac) begin
                    if (ac_valid(wr_byte[6:0])) ac <= wr_byte[6:0];
                    else                        perr <= 1'b1;
                end
            end
        end
    end

    assign lcd_data_out = data_out_q;
    assign lcd_data_oe  = oe_q && rw;
    assign busy         = busy_w;
    assign ddram_addr   = ac;
    assign four_bit     = !dl;
    assign two_line     = n_lines;
    assign disp_on      = d_on;
    assign cursor_on    = c_on;
    assign blink_on     = b_on;
    assign proto_err    = perr;
    assign rd_char      = rd_char_q;

endmodule
